arb2_stream: RTL and testbench
==============================

Name: arb2_stream

Overview:
- Two-input round-robin stream arbiter with a one-entry registered output stage.
- Sits directly upstream of the 2:1 Mux datapath. It decides, every cycle, which of two valid/ready sources (a, b) is forwarded.
- Exports the winning source as sel, using the same sel convention as Mux: 0 selects a, 1 selects b.
- Guarantees fairness: with both sources continuously requesting, grants alternate.

Parameters:
WIDTH  8  data width of a_data, b_data, out_data

Ports:
clk        input   1      system clock; all state changes on rising edge
rst        input   1      synchronous, active-high reset
a_valid    input   1      source a has a word on a_data
a_data     input   WIDTH  source a payload
a_ready    output  1      a word is accepted from a on this edge when a_valid && a_ready
b_valid    input   1      source b has a word on b_data
b_data     input   WIDTH  source b payload
b_ready    output  1      a word is accepted from b on this edge when b_valid && b_ready
out_valid  output  1      output register holds a word
out_data   output  WIDTH  held payload
out_ready  input   1      consumer takes the held word on this edge when out_valid && out_ready
sel        output  1      source of the held word (0 = a, 1 = b); Mux-compatible select

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge): out_valid=0, out_data=0, sel=0, internal last-grant pointer last=1 (so a wins the first tie).
- rst has priority over all other activity on the same edge. A held or in-flight word is dropped. a_ready and b_ready are 0 while rst=1.
- can_load = !out_valid || out_ready. The output register is empty or is being drained this edge.
- Winner selection (combinational):
  - Only a_valid asserted: a wins.
  - Only b_valid asserted: b wins.
  - Both asserted: the source opposite to last wins (last=1 gives a, last=0 gives b).
  - Neither asserted: no winner.
- a_ready = can_load && winner==a. b_ready = can_load && winner==b. The two are never both 1.
- Ready may depend combinationally on the valids. Sources must not make valid depend on ready.
- On an edge with can_load and a winner:
  - out_data <= winner data; sel <= winner id; out_valid <= 1; last <= winner id.
- On an edge with can_load and no winner:
  - out_valid <= 0 (if it was being drained); out_data, sel and last hold.
- On an edge with out_valid && !out_ready (stall):
  - out_data, sel, out_valid and last hold; both readys are 0.
- Latency and throughput:
  - Latency is 1 cycle: a word accepted at edge N is visible on out_data with out_valid=1 after edge N.
  - Full throughput of 1 word/cycle: with out_ready=1 a word can be drained and a new one loaded on the same edge.
- last updates only on an actual acceptance. Idle cycles and stalls do not change priority.
- A word is never duplicated or lost. Each accepted input produces exactly one output transfer, in acceptance order.
- The block performs no arithmetic. Data passes unchanged at full WIDTH.

Test Plan:
- rst=1 for 2 cycles, with a_valid=b_valid=1 -> out_valid=0, out_data=0, sel=0, a_ready=b_ready=0. After release, the first accepted word is from a (sel=0).
- a_valid=1, a_data=8'h3C, b_valid=0, out_ready=1 -> a_ready=1 at edge N. After N: out_valid=1, out_data=8'h3C, sel=0.
- Both valid continuously, a_data=8'hA1, b_data=8'hB2, out_ready=1 for 6 cycles -> outputs A1,B2,A1,B2,A1,B2 with sel 0,1,0,1,0,1, one per cycle.
- Hold a word 8'h55 from b, then out_ready=0 for 3 cycles with a_valid=1 -> out_data=8'h55, sel=1, out_valid=1 stable; a_ready=0 throughout. When out_ready returns to 1, a's word is loaded on that same edge.
- Accept from a, go idle 3 cycles, then assert both valids -> b wins (last unchanged by the idle cycles).
- Assert rst for 1 cycle while out_valid=1 and stalled -> next cycle out_valid=0, sel=0. After release with both valid, a wins first.

Source files
------------

// File: rtl/arb2_stream.sv
// Two-input round-robin valid/ready arbiter with a one-entry output register.
// sel follows the downstream 2:1 mux convention: 0 = a, 1 = b.
module arb2_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel
);

  logic last;
  logic can_load;
  logic win_a;
  logic win_b;

  // On a tie the source opposite the last grant wins.
  always_comb begin
    can_load = !out_valid || out_ready;
    win_a    = a_valid && (!b_valid || last);
    win_b    = b_valid && (!a_valid || !last);
    a_ready  = !rst && can_load && win_a;
    b_ready  = !rst && can_load && win_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sel       <= 1'b0;
      last      <= 1'b1;
    end else if (can_load) begin
      unique case (1'b1)
        win_a: begin
          out_data  <= a_data;
          sel       <= 1'b0;
          last      <= 1'b0;
          out_valid <= 1'b1;
        end
        win_b: begin
          out_data  <= b_data;
          sel       <= 1'b1;
          last      <= 1'b1;
          out_valid <= 1'b1;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_arb2_stream.sv
// Scenario bench for arb2_stream: per-feature tasks plus a
// scoreboard that matches every accepted word to its output transfer.
module tb_arb2_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       sel;

  int errors = 0;
  int checks = 0;

  logic [8:0] sb[$];

  arb2_stream #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .a_valid(a_valid),
    .a_data(a_data),
    .a_ready(a_ready),
    .b_valid(b_valid),
    .b_data(b_data),
    .b_ready(b_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .sel(sel)
  );

  always #5 clk = ~clk;

  // Inputs only change 1ns after a rising edge, so the falling edge
  // sees exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      sb.delete();
    end else begin
      checks++;
      if (a_ready === 1'b1 && b_ready === 1'b1) begin
        errors++;
        $display("FAIL both_ready: a_ready=%b b_ready=%b want not both",
                 a_ready, b_ready);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got %h sel=%b with nothing expected",
                   out_data, sel);
        end else begin
          logic [8:0] exp;
          exp = sb.pop_front();
          if ({sel, out_data} !== exp) begin
            errors++;
            $display("FAIL sb_order: got sel=%b data=%h want sel=%b data=%h",
                     sel, out_data, exp[8], exp[7:0]);
          end
        end
      end
      if (a_valid === 1'b1 && a_ready === 1'b1) sb.push_back({1'b0, a_data});
      if (b_valid === 1'b1 && b_ready === 1'b1) sb.push_back({1'b1, b_data});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 1'b1; a_data = 8'h5A;
    b_valid = 1'b1; b_data = 8'hB5;
    out_ready = 1'b1;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h s=%b want v=0 d=00 s=0",
               out_valid, out_data, sel);
    end
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got a=%b b=%b want a=0 b=0",
               a_ready, b_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_tie: got a=%b b=%b want a=1 b=0",
               a_ready, b_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_word: got v=%b d=%h s=%b want v=1 d=5a s=0",
               out_valid, out_data, sel);
    end
  endtask

  task automatic test_single();
    a_valid = 1'b1; a_data = 8'h3C;
    b_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got a_ready=%b want 1", a_ready);
    end
    step();
    a_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C || sel !== 1'b0) begin
      errors++;
      $display("FAIL single_out: got v=%b d=%h s=%b want v=1 d=3c s=0",
               out_valid, out_data, sel);
    end
  endtask

  task automatic test_alternate();
    logic [7:0] want;
    b_valid = 1'b1; b_data = 8'h77;
    out_ready = 1'b1;
    step();
    a_valid = 1'b1; a_data = 8'hA1;
    b_data = 8'hB2;
    for (int i = 0; i < 6; i++) begin
      step();
      want = (i % 2 == 1) ? 8'hB2 : 8'hA1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== want || sel !== i[0]) begin
        errors++;
        $display("FAIL alternate_%0d: got v=%b d=%h s=%b want v=1 d=%h s=%b",
                 i, out_valid, out_data, sel, want, i[0]);
      end
    end
    step();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    step();
    b_valid = 1'b1; b_data = 8'h55;
    step();
    b_valid = 1'b0;
    a_valid = 1'b1; a_data = 8'hC3;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h55 || sel !== 1'b1 ||
          a_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d: got v=%b d=%h s=%b ar=%b want v=1 d=55 s=1 ar=0",
                 i, out_valid, out_data, sel, a_ready);
      end
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: got a_ready=%b want 1", a_ready);
    end
    step();
    a_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hC3 || sel !== 1'b0) begin
      errors++;
      $display("FAIL stall_release_out: got v=%b d=%h s=%b want v=1 d=c3 s=0",
               out_valid, out_data, sel);
    end
  endtask

  task automatic test_idle_priority();
    out_ready = 1'b1;
    step();
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_drained: got out_valid=%b want 0", out_valid);
    end
    a_valid = 1'b1; a_data = 8'h11;
    b_valid = 1'b1; b_data = 8'h22;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_tie_ready: got a=%b b=%b want a=0 b=1",
               a_ready, b_ready);
    end
    step();
    a_valid = 1'b0;
    b_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h22 || sel !== 1'b1) begin
      errors++;
      $display("FAIL idle_tie_out: got v=%b d=%h s=%b want v=1 d=22 s=1",
               out_valid, out_data, sel);
    end
  endtask

  task automatic test_reset_stall();
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || sel !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_stall_state: got v=%b d=%h s=%b want v=0 d=00 s=0",
               out_valid, out_data, sel);
    end
    rst = 1'b0;
    a_valid = 1'b1; a_data = 8'h9E;
    b_valid = 1'b1; b_data = 8'hE9;
    out_ready = 1'b1;
    step();
    a_valid = 1'b0;
    b_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h9E || sel !== 1'b0) begin
      errors++;
      $display("FAIL rst_stall_first: got v=%b d=%h s=%b want v=1 d=9e s=0",
               out_valid, out_data, sel);
    end
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    step();
    step();
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: got pending=%0d v=%b want pending=0 v=0",
               sb.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_idle_priority();
    test_reset_stall();
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
